btn_repeat: RTL

- Push-button front end feeding the speed up/down counter of the LED blink logic.
- Synchronises a raw active-high button and debounces it on a 1 ms tick.
- Emits a one-cycle PULSE on press, then auto-repeat PULSEs while the button is held.
- Replaces bare debounce at each BTN input, so holding a button steps speed continuously.

---
 rtl/btn_repeat.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/btn_repeat.sv
// Button front end: sync, tick-based debounce, press pulse plus auto-repeat pulses while held.
// Latency: BTNIN to LEVEL/press PULSE is at most 2 + DB_TICKS*TICK_DIV cycles; outputs are registered.
// Backpressure: none; PULSE is a one-cycle strobe that the consumer must take when it is high.
//
// Ports:
//    CLK    system clock
//    RST    asynchronous active-high reset
//    BTNIN  raw active-high button, asynchronous to CLK
//    PULSE  one-cycle strobe on a press or on each auto-repeat
//    LEVEL  debounced button level
//    HELD   high while auto-repeat is active
module btn_repeat #(
   parameter int TICK_DIV   = 125000,
   parameter int DB_TICKS   = 10,
   parameter int HOLD_TICKS = 500,
   parameter int RPT_TICKS  = 100
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTNIN,
   output logic PULSE,
   output logic LEVEL,
   output logic HELD
);

   localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
   localparam int DW = (DB_TICKS   > 1) ? $clog2(DB_TICKS)   : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int RW = (RPT_TICKS  > 1) ? $clog2(RPT_TICKS)  : 1;

   localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] D_MAX = DW'(DB_TICKS - 1);
   localparam logic [HW-1:0] H_MAX = HW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] R_MAX = RW'(RPT_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [PW-1:0] pcnt_q,  pcnt_d;
   logic [DW-1:0] dbcnt_q, dbcnt_d;
   logic [HW-1:0] hcnt_q,  hcnt_d;
   logic [RW-1:0] rcnt_q,  rcnt_d;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;
   logic          held_q,  held_d;
   state_t        state_q, state_d;

   logic tick;
   logic rise;
   logic fall;

   always_comb begin
      tick    = (pcnt_q == P_MAX);
      pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
      sync1_d = BTNIN;
      sync2_d = sync1_q;

      // Debounce: LEVEL only moves after DB_TICKS consecutive disagreeing ticks.
      level_d = level_q;
      dbcnt_d = dbcnt_q;
      if (tick) begin
         if (sync2_q != level_q) begin
            if (dbcnt_q == D_MAX) begin
               level_d = ~level_q;
               dbcnt_d = '0;
            end else begin
               dbcnt_d = dbcnt_q + DW'(1);
            end
         end else begin
            dbcnt_d = '0;
         end
      end

      // Edges are taken from the next LEVEL so the press pulse lands in the
      // same cycle LEVEL goes high.
      rise = tick & level_d & ~level_q;
      fall = tick & ~level_d & level_q;

      state_d = state_q;
      hcnt_d  = hcnt_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      held_d  = held_q;

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESS;
               pulse_d = 1'b1;
               hcnt_d  = '0;
            end
         end
         PRESS: begin
            // Release is checked first so it wins over a coincident hold expiry.
            if (fall) begin
               state_d = IDLE;
            end else if (tick) begin
               if (hcnt_q == H_MAX) begin
                  state_d = REPEAT;
                  pulse_d = 1'b1;
                  held_d  = 1'b1;
                  rcnt_d  = '0;
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
         end
         REPEAT: begin
            if (fall) begin
               state_d = IDLE;
               held_d  = 1'b0;
            end else if (tick) begin
               if (rcnt_q == R_MAX) begin
                  pulse_d = 1'b1;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            held_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         pcnt_q  <= '0;
         dbcnt_q <= '0;
         hcnt_q  <= '0;
         rcnt_q  <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         held_q  <= 1'b0;
         state_q <= IDLE;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         pcnt_q  <= pcnt_d;
         dbcnt_q <= dbcnt_d;
         hcnt_q  <= hcnt_d;
         rcnt_q  <= rcnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         held_q  <= held_d;
         state_q <= state_d;
      end
   end

   assign PULSE = pulse_q;
   assign LEVEL = level_q;
   assign HELD  = held_q;

endmodule
